exec_unit_seq: RTL and testbench

//  Sequential, parametrised successor to the combinational execute stage: same

---
 rtl/exec_unit_pkg.sv | 66 ++++++
 rtl/exec_unit_seq_muldiv_iter.sv | 117 +++++++++++
 rtl/exec_unit_seq.sv | 132 +++++++++++++
 tb/tb_exec_unit_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared types for the sequential execute stage and its iterative mul/div unit.
// Operand selects, ALU/M-extension opcodes, FSM states and opcode helpers.
package exec_unit_pkg;

  typedef enum logic {
    OP1_SEL_RS1,
    OP1_SEL_PC
  } op1_sel_e;

  typedef enum logic {
    OP2_SEL_RS2,
    OP2_SEL_IMM
  } op2_sel_e;

  typedef enum logic [3:0] {
    EXEC_ADD,
    EXEC_SUB,
    EXEC_SLL,
    EXEC_SLT,
    EXEC_SLTU,
    EXEC_XOR,
    EXEC_SRL,
    EXEC_SRA,
    EXEC_OR,
    EXEC_AND,
    EXEC_PASS2
  } exec_op_e;

  typedef struct packed {
    op1_sel_e operand1_sel;
    op2_sel_e operand2_sel;
    exec_op_e exec_op;
  } exec_unit_params;

  // Encoded exactly as RV funct3 so decode can pass the field straight through.
  typedef enum logic [2:0] {
    MD_MUL,
    MD_MULH,
    MD_MULHSU,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_REM,
    MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } exec_seq_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_a_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/exec_unit_seq_muldiv_iter.sv
// Iterative multiply (shift-add, MUL_RADIX bits/step) and restoring divide.
// Works on magnitudes; the sign fix-up is folded into the last iteration's result.
module muldiv_iter
  import exec_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_RADIX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int MUL_ITERS = XLEN / MUL_RADIX;
  localparam int CW        = $clog2(XLEN) + 1;

  md_op_e            op_q;
  logic              active;
  logic              neg_res;
  logic [CW-1:0]     count;
  logic [CW-1:0]     last_q;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc, mcand, mul_add, acc_nxt, prod;
  logic [XLEN-1:0]   mplier, divisor, quo, rem;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix;
  logic [XLEN:0]     rem_shift, diff;

  assign a_neg = md_a_signed(op) & a[XLEN-1];
  assign b_neg = md_b_signed(op) & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One step of both datapaths; only the one matching op_q is committed.
  always_comb begin
    mul_add = '0;
    for (int i = 0; i < MUL_RADIX; i++) begin
      if (mplier[i]) mul_add = mul_add + (mcand << i);
    end
    acc_nxt   = acc + mul_add;
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    rem_nxt   = diff[XLEN-1:0];
    quo_nxt   = {quo[XLEN-2:0], 1'b1};
    if (diff[XLEN]) begin
      rem_nxt = rem_shift[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod    = neg_res ? -acc_nxt : acc_nxt;
    quo_fix = neg_res ? -quo_nxt : quo_nxt;
    rem_fix = neg_res ? -rem_nxt : rem_nxt;
    result  = rem_fix;
    case (op_q)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  assign done = active && (count == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MD_MUL;
      active  <= 1'b0;
      neg_res <= 1'b0;
      count   <= '0;
      last_q  <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
    end else if (flush) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      op_q    <= op;
      active  <= 1'b1;
      count   <= '0;
      // Remainder takes the dividend's sign; everything else the XOR of signs.
      neg_res <= (md_is_div(op) && op[1]) ? a_neg : (a_neg ^ b_neg);
      last_q  <= md_is_div(op) ? CW'(XLEN - 1) : CW'(MUL_ITERS - 1);
      acc     <= '0;
      mcand   <= {{XLEN{1'b0}}, a_mag};
      mplier  <= b_mag;
      quo     <= a_mag;
      rem     <= '0;
      divisor <= b_mag;
    end else if (active) begin
      count <= count + CW'(1);
      if (md_is_div(op_q)) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
      end else begin
        acc    <= acc_nxt;
        mcand  <= mcand << MUL_RADIX;
        mplier <= mplier >> MUL_RADIX;
      end
      if (done) begin
        active <= 1'b0;
        count  <= '0;
      end
    end
  end

endmodule

// File: rtl/exec_unit_seq.sv
// Sequential execute stage: single-cycle ALU ops plus iterative RV M-extension,
// valid/ready on both sides, one operation in flight at a time.
module exec_unit_seq
  import exec_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_RADIX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm_val,
  input  exec_unit_params params,
  input  logic            is_muldiv,
  input  logic [2:0]      md_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] exec_out,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  exec_seq_state_e state, state_nxt;
  md_op_e          md_kind;
  logic [XLEN-1:0] op1, op2, alu_res, div_special_res, md_result, res_nxt;
  logic [SHW-1:0]  shamt;
  logic            accept, md_start, md_done, load_res;
  logic            div_by_zero, div_overflow, div_special;

  assign md_kind = md_op_e'(md_op);
  assign op1     = (params.operand1_sel == OP1_SEL_PC) ? pc : rs1;
  assign op2     = (params.operand2_sel == OP2_SEL_IMM) ? imm_val : rs2;
  assign shamt   = op2[SHW-1:0];

  always_comb begin
    alu_res = op1 + op2;
    case (params.exec_op)
      EXEC_SUB:   alu_res = op1 - op2;
      EXEC_SLL:   alu_res = op1 << shamt;
      EXEC_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      EXEC_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      EXEC_XOR:   alu_res = op1 ^ op2;
      EXEC_SRL:   alu_res = op1 >> shamt;
      EXEC_SRA:   alu_res = $unsigned($signed(op1) >>> shamt);
      EXEC_OR:    alu_res = op1 | op2;
      EXEC_AND:   alu_res = op1 & op2;
      EXEC_PASS2: alu_res = op2;
      default:    alu_res = op1 + op2;
    endcase
  end

  // Divide corner cases resolve at acceptance and never start the iterator.
  assign div_by_zero     = (rs2 == '0);
  assign div_overflow    = md_a_signed(md_kind) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign div_special     = md_is_div(md_kind) && (div_by_zero || div_overflow);
  assign div_special_res = div_by_zero ? (md_kind[1] ? rs1 : '1) : (md_kind[1] ? '0 : rs1);

  assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);

  always_comb begin
    state_nxt = state;
    md_start  = 1'b0;
    load_res  = 1'b0;
    res_nxt   = alu_res;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (!is_muldiv) begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end else if (div_special) begin
            state_nxt = DONE;
            load_res  = 1'b1;
            res_nxt   = div_special_res;
          end else begin
            state_nxt = md_is_div(md_kind) ? DIV : MUL;
            md_start  = 1'b1;
          end
        end else if ((state == IDLE) || out_ready) begin
          state_nxt = IDLE;
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          state_nxt = DONE;
          load_res  = 1'b1;
          res_nxt   = md_result;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      md_start  = 1'b0;
      load_res  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      exec_out <= '0;
    end else begin
      state <= state_nxt;
      if (load_res) exec_out <= res_nxt;
    end
  end

  muldiv_iter #(
    .XLEN      (XLEN),
    .MUL_RADIX (MUL_RADIX)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .op     (md_kind),
    .a      (rs1),
    .b      (rs2),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_exec_unit_seq.sv
// Bench for exec_unit_seq: vector table through a result scoreboard, plus
// back-to-back, backpressure, flush and mid-multiply reset sequences.
module tb_exec_unit_seq;
  import exec_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, is_muldiv;
  logic            out_valid, out_ready, busy;
  logic [31:0]     pc, rs1, rs2, imm_val, exec_out;
  logic [2:0]      md_op;
  exec_unit_params params;

  typedef struct {
    logic        is_md;
    logic [2:0]  md;
    exec_op_e    op;
    op1_sel_e    s1;
    op2_sel_e    s2;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          acc_cyc;
    int          lat;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  bit   lat_done = 1'b0;

  exec_unit_seq #(.XLEN(32), .MUL_RADIX(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc        (pc),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm_val   (imm_val),
    .params    (params),
    .is_muldiv (is_muldiv),
    .md_op     (md_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exec_out  (exec_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t alu_vec(exec_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    vec_t v;
    v.is_md = 1'b0; v.md = 3'd0; v.op = op; v.s1 = OP1_SEL_RS1; v.s2 = OP2_SEL_RS2;
    v.pc = 32'd0; v.rs1 = a; v.rs2 = b; v.imm = 32'd0; v.exp = e; v.lat = 1;
    return v;
  endfunction

  function automatic vec_t md_vec(md_op_e m, logic [31:0] a, logic [31:0] b, logic [31:0] e, int lat);
    vec_t v;
    v = alu_vec(EXEC_ADD, a, b, e);
    v.is_md = 1'b1; v.md = m; v.lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic applyStimulus(input vec_t v, input bit track);
    bit  accepted;
    sb_t e;
    accepted = 1'b0;
    is_muldiv = v.is_md; md_op = v.md;
    params.exec_op = v.op; params.operand1_sel = v.s1; params.operand2_sel = v.s2;
    pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; imm_val = v.imm;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (track) begin
          e.exp = v.exp; e.acc_cyc = cyc; e.lat = v.lat;
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
      if (accepted) break;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      lat_done = 1'b0;
    end
  endtask

  // Scoreboard consumer: latency on first out_valid, data on the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!lat_done) begin
          checkOutput("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
          lat_done = 1'b1;
        end
        if (out_ready) begin
          checkOutput("exec_out", exec_out, sb[0].exp);
          void'(sb.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before 1ms");
    $fatal(1);
  end

  initial begin
    int start_cyc;
    int ov_count;
    vec_t v;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    is_muldiv = 1'b0; md_op = 3'd0; pc = '0; rs1 = '0; rs2 = '0; imm_val = '0;
    params = '{OP1_SEL_RS1, OP2_SEL_RS2, EXEC_ADD};
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_exec_out", exec_out, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(alu_vec(EXEC_ADD,  32'd5, 32'd7, 32'd12));
    vecs.push_back(alu_vec(EXEC_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE));
    v = alu_vec(EXEC_SLL, 32'd1, 32'd0, 32'd8); v.s2 = OP2_SEL_IMM; v.imm = 32'h23;
    vecs.push_back(v);
    vecs.push_back(alu_vec(EXEC_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000));
    vecs.push_back(alu_vec(EXEC_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000));
    vecs.push_back(alu_vec(EXEC_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1));
    vecs.push_back(alu_vec(EXEC_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0));
    vecs.push_back(alu_vec(EXEC_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0));
    v = alu_vec(EXEC_ADD, 32'hDEAD_BEEF, 32'd0, 32'h0000_1004);
    v.s1 = OP1_SEL_PC; v.pc = 32'h0000_1000; v.s2 = OP2_SEL_IMM; v.imm = 32'd4;
    vecs.push_back(v);
    vecs.push_back(alu_vec(exec_op_e'(4'hF), 32'd3, 32'd4, 32'd7));
    vecs.push_back(md_vec(MD_MUL,    32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 17));
    vecs.push_back(md_vec(MD_MUL,    32'h1234_5678, 32'h10, 32'h2345_6780, 17));
    vecs.push_back(md_vec(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17));
    vecs.push_back(md_vec(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17));
    vecs.push_back(md_vec(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17));
    vecs.push_back(md_vec(MD_DIV,    32'd7, 32'd0, 32'hFFFF_FFFF, 1));
    vecs.push_back(md_vec(MD_REM,    32'd7, 32'd0, 32'd7, 1));
    vecs.push_back(md_vec(MD_DIVU,   32'd5, 32'd0, 32'hFFFF_FFFF, 1));
    vecs.push_back(md_vec(MD_REMU,   32'd9, 32'd0, 32'd9, 1));
    vecs.push_back(md_vec(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
    vecs.push_back(md_vec(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1));
    vecs.push_back(md_vec(MD_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33));
    vecs.push_back(md_vec(MD_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33));
    vecs.push_back(md_vec(MD_DIVU,   32'd100, 32'd7, 32'd14, 33));
    vecs.push_back(md_vec(MD_REMU,   32'd100, 32'd7, 32'd2, 33));
    vecs.push_back(md_vec(MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b1);
      waitDrain();
    end

    $display("[TB] back-to-back ALU sequence");
    start_cyc = cyc;
    for (int i = 0; i < 4; i++)
      applyStimulus(alu_vec(EXEC_ADD, 32'(i * 10), 32'd1, 32'(i * 10 + 1)), 1'b1);
    checkOutput("b2b_accept_cycles", 32'(cyc - start_cyc), 32'd4);
    waitDrain();

    $display("[TB] backpressure sequence");
    out_ready = 1'b0;
    applyStimulus(alu_vec(EXEC_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_exec_out", exec_out, 32'hA5A5_5A5A);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] flush during divide");
    applyStimulus(md_vec(MD_DIV, 32'd1000, 32'd3, 32'd333, 33), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    is_muldiv = 1'b0; params.exec_op = EXEC_ADD; rs1 = 32'd1; rs2 = 32'd1;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_busy_after", 32'(busy), 32'd0);
    ov_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov_count++;
    end
    checkOutput("flush_out_valid_cycles", 32'(ov_count), 32'd0);
    @(posedge clk); #1;
    applyStimulus(alu_vec(EXEC_ADD, 32'd20, 32'd22, 32'd42), 1'b1);
    waitDrain();

    $display("[TB] reset during multiply");
    applyStimulus(alu_vec(EXEC_OR, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0), 1'b1);
    waitDrain();
    applyStimulus(md_vec(MD_MUL, 32'd1234, 32'd5678, 32'd0, 17), 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("mul_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_exec_out", exec_out, 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(alu_vec(EXEC_ADD, 32'd3, 32'd4, 32'd7), 1'b1);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
